// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the decryption-path column stages.
// Column helpers map between the 128-bit state and one 4-byte lane {a0,a1,a2,a3}.
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } imc_fsm_t;

  localparam logic [7:0] AES_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Byte j of every word, word 0 in the top byte of the result.
  function automatic logic [31:0] get_column(input aes_state_t s, input logic [1:0] j);
    case (j)
      2'd0:    return {s[103:96],  s[71:64], s[39:32], s[7:0]};
      2'd1:    return {s[111:104], s[79:72], s[47:40], s[15:8]};
      2'd2:    return {s[119:112], s[87:80], s[55:48], s[23:16]};
      default: return {s[127:120], s[95:88], s[63:56], s[31:24]};
    endcase
  endfunction

  function automatic aes_state_t put_column(input aes_state_t s, input logic [1:0] j,
                                            input logic [31:0] c);
    aes_state_t r;
    r = s;
    case (j)
      2'd0: begin
        r[103:96] = c[31:24]; r[71:64] = c[23:16]; r[39:32] = c[15:8]; r[7:0]   = c[7:0];
      end
      2'd1: begin
        r[111:104] = c[31:24]; r[79:72] = c[23:16]; r[47:40] = c[15:8]; r[15:8] = c[7:0];
      end
      2'd2: begin
        r[119:112] = c[31:24]; r[87:80] = c[23:16]; r[55:48] = c[15:8]; r[23:16] = c[7:0];
      end
      default: begin
        r[127:120] = c[31:24]; r[95:88] = c[23:16]; r[63:56] = c[15:8]; r[31:24] = c[7:0];
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inv_mix_lane.sv
// Combinational InvMixColumns for one 4-byte lane; byte a0 sits in col_in[31:24].
module inv_mix_lane
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col_in;

  assign col_out = {
    gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
    gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
    gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
    gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)
  };

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative InvMixColumns: LANES_PER_CYCLE lanes per BUSY cycle, valid/ready on both sides.
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int unsigned LANES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  if (!(LANES_PER_CYCLE == 1 || LANES_PER_CYCLE == 2 || LANES_PER_CYCLE == 4)) begin : g_bad_lanes
    $error("inv_mix_columns_iter: LANES_PER_CYCLE must be 1, 2 or 4");
  end

  // A step of 4 truncates to 0, so lane_cnt stays at 0 for the single-cycle variant.
  localparam logic [1:0] LANE_STEP = 2'(LANES_PER_CYCLE);
  localparam logic [1:0] LAST_LANE = 2'(4 - LANES_PER_CYCLE);

  imc_fsm_t   fsm;
  logic [1:0] lane_cnt;
  aes_state_t in_reg;
  aes_state_t res_reg;
  aes_state_t res_chain [LANES_PER_CYCLE+1];
  logic       accept;

  assign res_chain[0] = res_reg;

  for (genvar i = 0; i < LANES_PER_CYCLE; i++) begin : g_lane
    logic [1:0]  lane_sel;
    logic [31:0] col_in;
    logic [31:0] col_out;

    assign lane_sel = lane_cnt + 2'(i);
    assign col_in   = get_column(in_reg, lane_sel);

    inv_mix_lane u_lane (
      .col_in (col_in),
      .col_out(col_out)
    );

    assign res_chain[i+1] = put_column(res_chain[i], lane_sel, col_out);
  end

  assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign state_out = res_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      lane_cnt  <= '0;
      in_reg    <= '0;
      res_reg   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            in_reg   <= state_in;
            lane_cnt <= '0;
            busy     <= 1'b1;
            fsm      <= BUSY;
          end
        end
        BUSY: begin
          res_reg  <= res_chain[LANES_PER_CYCLE];
          lane_cnt <= lane_cnt + LANE_STEP;
          if (lane_cnt == LAST_LANE) begin
            lane_cnt  <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              in_reg   <= state_in;
              lane_cnt <= '0;
              busy     <= 1'b1;
              fsm      <= BUSY;
            end else begin
              fsm <= IDLE;
            end
          end
        end
        default: begin
          fsm       <= IDLE;
          lane_cnt  <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
